// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word-aligned imem requests, buffers
// in-order responses together with their PC, and handles branch redirects
// by flushing the buffer and draining responses still in flight.
`timescale 1ns/1ps
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_OUT  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [CW-1:0] outst;
  logic [CW-1:0] fcnt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   buf_instr [MAX_OUT];
  logic [31:0]   buf_pc    [MAX_OUT];

  logic [CW:0]   inflight;
  logic          grant;
  logic          rsp;
  logic          wr;
  logic          pop;
  logic [CW-1:0] outst_nxt;
  logic [31:0]   resp_pc;

  // Circular-buffer pointer advance; MAX_OUT need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUT - 1)) ? '0 : p + AW'(1);
  endfunction

  // Issue/accept decisions for the current cycle.
  always_comb begin
    inflight  = {1'b0, outst} + {1'b0, fcnt};
    imem_req  = !RST && (state == RUN) && !redirect_valid &&
                (inflight < (CW+1)'(MAX_OUT));
    imem_addr = fpc;
    grant     = imem_req && imem_gnt;
    rsp       = imem_rvalid && (outst != '0);
    // Responses are only kept in RUN and never in a redirect cycle.
    wr        = rsp && (state == RUN) && !redirect_valid;
    pop       = instr_valid && instr_ready;
    outst_nxt = outst + CW'(grant) - CW'(rsp);
    // Requests are sequential, so the oldest one in flight sits outst words behind fpc.
    resp_pc   = fpc - (32'(outst) << 2);
  end

  assign instr_valid = !RST && (fcnt != '0);
  assign instr       = buf_instr[rptr];
  assign instr_pc    = buf_pc[rptr];

  // Control state: fetch pointer, RUN/DRAIN, in-flight count, buffer occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      fpc   <= RESET_PC;
      outst <= '0;
      fcnt  <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      outst <= outst_nxt;
      if (redirect_valid) begin
        // fpc doubles as the pending redirect target while draining.
        fpc   <= {redirect_pc[31:2], 2'b00};
        fcnt  <= '0;
        wptr  <= '0;
        rptr  <= '0;
        state <= (outst_nxt != '0) ? DRAIN : RUN;
      end else begin
        if (grant)
          fpc <= fpc + 32'd4;
        if ((state == DRAIN) && (outst_nxt == '0))
          state <= RUN;
        fcnt <= fcnt + CW'(wr) - CW'(pop);
        if (wr)
          wptr <= ptr_inc(wptr);
        if (pop)
          rptr <= ptr_inc(rptr);
      end
    end
  end

  // Buffer storage: instruction word and its PC, written on accepted responses.
  always_ff @(posedge CLK) begin
    if (wr) begin
      buf_instr[wptr] <= imem_rdata;
      buf_pc[wptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: an in-order memory responder, a scoreboard of
// expected request addresses and delivered instructions, and directed tests.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic        resp_en = 1'b1;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_pc_q   [$];
  logic [31:0] pend_q     [$];

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .MAX_OUT(2)) dut (
    .CLK(CLK), .RST(RST),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sample handshakes on the falling edge and score them.
  always @(negedge CLK) begin
    if (!RST) begin
      if (imem_req && imem_gnt) begin
        pend_q.push_back(imem_addr);
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_req: got addr %h expected none", imem_addr);
        end else
          chk("imem_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (instr_valid && instr_ready) begin
        if (exp_pc_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
        end else begin
          logic [31:0] epc;
          epc = exp_pc_q.pop_front();
          chk("instr_pc", instr_pc, epc);
          chk("instr", instr, mem_word(epc));
        end
      end
    end
  end

  // Memory responder: in order, one response per cycle, one cycle after grant.
  always @(posedge CLK) begin
    #2;
    if (RST) begin
      pend_q.delete();
      imem_rvalid = 1'b0;
    end else begin
      if (imem_rvalid) void'(pend_q.pop_front());
      if (resp_en && pend_q.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_q[0]);
      end else
        imem_rvalid = 1'b0;
    end
  end

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic grant_n(input int n, input string name);
    int got = 0;
    int cyc = 0;
    imem_gnt = 1'b1;
    while (got < n && cyc < 60) begin
      @(negedge CLK);
      if (imem_req) got++;
      @(posedge CLK); #1;
      cyc++;
    end
    imem_gnt = 1'b0;
    chk({name, "_grants"}, 32'(got), 32'(n));
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0 ||
            pend_q.size() != 0 || imem_rvalid) && cyc < 100) begin
      tick;
      cyc++;
    end
    chk({name, "_idle_in_time"}, 32'(cyc < 100), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    chk("req_in_redirect_cycle", 32'(imem_req), 32'd0);
    tick;
    redirect_valid = 1'b0;
  endtask

  task automatic push_both(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_pc_q.push_back(a);
  endtask

  initial begin
    int got;
    // Reset state.
    RST = 1'b1;
    tick;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    tick;
    RST = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_valid", 32'(instr_valid), 32'd0);

    // Streaming fetch: 0,4,8 in order.
    push_both(32'h0); push_both(32'h4); push_both(32'h8);
    grant_n(3, "stream");
    wait_idle("stream");

    // Back-pressure: only MAX_OUT=2 fetched while decode stalls.
    instr_ready = 1'b0;
    exp_addr_q.push_back(32'hC); exp_addr_q.push_back(32'h10);
    imem_gnt = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (imem_req) got++;
      @(posedge CLK); #1;
    end
    imem_gnt = 1'b0;
    #1;
    chk("stall_grants", 32'(got), 32'd2);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    exp_pc_q.push_back(32'hC); exp_pc_q.push_back(32'h10);
    push_both(32'h14); push_both(32'h18);
    instr_ready = 1'b1;
    grant_n(2, "resume");
    wait_idle("resume");

    // Redirect with two outstanding: both responses discarded.
    resp_en = 1'b0;
    exp_addr_q.push_back(32'h1C); exp_addr_q.push_back(32'h20);
    grant_n(2, "pre_drain");
    tick; tick;
    chk("full_req", 32'(imem_req), 32'd0);
    do_redirect(32'h100);
    resp_en = 1'b1;
    push_both(32'h100);
    #1;
    chk("drain_req", 32'(imem_req), 32'd0);
    chk("drain_valid", 32'(instr_valid), 32'd0);
    grant_n(1, "post_drain");
    wait_idle("post_drain");

    // Second redirect during DRAIN replaces the target.
    resp_en = 1'b0;
    exp_addr_q.push_back(32'h104); exp_addr_q.push_back(32'h108);
    grant_n(2, "pre_drain2");
    do_redirect(32'h203);
    #1;
    chk("drain2_valid", 32'(instr_valid), 32'd0);
    do_redirect(32'h300);
    resp_en = 1'b1;
    push_both(32'h300);
    grant_n(1, "post_drain2");
    wait_idle("post_drain2");

    // Unaligned target is word-aligned; no outstanding so no drain.
    do_redirect(32'h203);
    push_both(32'h200);
    #1;
    chk("align_addr", imem_addr, 32'h200);
    chk("align_req", 32'(imem_req), 32'd1);
    grant_n(1, "align");
    wait_idle("align");

    // Grant withheld: address stable, redirect withdraws the request.
    tick;
    chk("hold1_req", 32'(imem_req), 32'd1);
    chk("hold1_addr", imem_addr, 32'h204);
    tick;
    chk("hold2_addr", imem_addr, 32'h204);
    do_redirect(32'h400);
    #1;
    chk("hold3_req", 32'(imem_req), 32'd1);
    chk("hold3_addr", imem_addr, 32'h400);
    push_both(32'h400);
    grant_n(1, "hold");
    wait_idle("hold");

    // Address wrap at the top of memory.
    do_redirect(32'hFFFF_FFFC);
    push_both(32'hFFFF_FFFC); push_both(32'h0);
    grant_n(2, "wrap");
    wait_idle("wrap");

    // Reset mid-operation abandons the in-flight request at 0x4.
    resp_en = 1'b0;
    exp_addr_q.push_back(32'h4);
    grant_n(1, "pre_reset");
    RST = 1'b1;
    tick;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    tick;
    RST = 1'b0;
    resp_en = 1'b1;
    #1;
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid_after", 32'(instr_valid), 32'd0);
    push_both(32'h0);
    grant_n(1, "after_reset");
    wait_idle("after_reset");
    tick; tick;
    chk("final_valid", 32'(instr_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
